gate_truth_table_checker: RTL

//   Clocked driver and checker for any 2-input logic gate under test.
//   On start, drives dut_a/dut_b through {A,B} = 00,01,10,11 and waits a settle time.
//   It samples dut_y and compares it against the expected truth table.

---
 rtl/gate_truth_table_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
//   Clocked stimulus driver and response checker for a 2-input logic gate.
//   A run drives {dut_a,dut_b} through 00,01,10,11. After each vector it
//   waits SETTLE_CYCLES clocks, then compares dut_y with TRUTH_TABLE[{A,B}].
//   At the end it reports pass, err_count and fail_vec with a one-cycle done pulse.
//   Optional feature: define CHECKER_STOP_ON_FAIL_EN to end the run at the
//   first mismatching vector instead of always running all four.

module gate_truth_table_checker #(
    parameter logic [3:0]  TRUTH_TABLE   = 4'b0111,  // expected Y, bit index = {A,B}
    parameter int unsigned SETTLE_CYCLES = 2         // 0..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_y,
    output logic       dut_a,
    output logic       dut_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam bit         HAS_SETTLE  = (SETTLE_CYCLES != 0);
    // Loaded in DRIVE so that SETTLE lasts exactly SETTLE_CYCLES clocks.
    localparam logic [3:0] SETTLE_LOAD = HAS_SETTLE ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_next;
    logic [1:0] combo;       // vector currently under test, {A,B}
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic       last_vec;

    // X or Z on the gate output must count as a failure, so use case inequality.
    assign mismatch = (dut_y !== TRUTH_TABLE[combo]);
    assign last_vec = (combo == 2'd3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update together from the values present before the edge.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:   if (start) state_next = ST_DRIVE;
            ST_DRIVE:  state_next = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
            ST_SETTLE: if (settle_cnt == 4'd0) state_next = ST_SAMPLE;
            ST_SAMPLE: begin
`ifdef CHECKER_STOP_ON_FAIL_EN
                if (mismatch || last_vec) state_next = ST_DONE;
                else                      state_next = ST_DRIVE;
`else
                if (last_vec) state_next = ST_DONE;
                else          state_next = ST_DRIVE;
`endif
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Combinational outputs.
    always_comb begin
        busy = (state != ST_IDLE);
    end

    // Datapath: vector sequencing, settle timer, result accumulation, registered done/pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo      <= 2'd0;
            settle_cnt <= 4'd0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
        end else begin
            // Registered pulse: high for the single cycle after the DONE state.
            done <= (state == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        combo     <= 2'd0;
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    dut_a      <= combo[1];
                    dut_b      <= combo[0];
                    settle_cnt <= SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                ST_SAMPLE: begin
                    // At most four vectors, so the 3-bit count cannot wrap.
                    if (mismatch) begin
                        err_count <= err_count + 3'd1;
                        fail_vec  <= fail_vec | (4'b0001 << combo);
                    end
                    if (!last_vec) combo <= combo + 2'd1;
                end
                ST_DONE: begin
                    // err_count already includes the final SAMPLE update here.
                    pass <= (err_count == 3'd0);
                end
                default: ;
            endcase
        end
    end

endmodule
